rob_multi: RTL and testbench

Parametrised reorder buffer for the out-of-order RISC-V core, successor to the single-commit ROB. It sits between the dispatcher (allocation and operand lookup), the RS/LSB result buses (N_CDB ports), and the commit consumers (register file, LSB store release, predictor, instruction fetch redirect). It adds the following over the previous generation:

- full-depth occupancy;
- configurable commit width;
- same-cycle CDB bypass on operand lookup;
- JALR target misprediction detection.

---
 rtl/rob_pkg.sv | 41 ++++
 rtl/rob_multi_commit_sel.sv | 33 +++
 rtl/rob_multi.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rob_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared kind encodings, entry layout and id type for the reorder buffer
package rob_pkg;

    localparam int ROB_DEPTH = 16;

    typedef logic [$clog2(ROB_DEPTH)-1:0] ROB_ID_T;

    typedef enum logic [2:0] {
        KIND_ALU    = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_STORE  = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JAL    = 3'd4,
        KIND_JALR   = 3'd5
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rd;
        logic [31:0] pred_pc;
        logic        pred_jump;
        logic [31:0] code;
        logic [31:0] value;
        logic        jump;
        logic [31:0] pc_next;
    } rob_entry_t;

    function automatic logic is_ctrl(kind_e k);
        return k inside {KIND_BRANCH, KIND_JAL, KIND_JALR};
    endfunction

    // A store or control-flow entry must be the last slot committed in a cycle.
    function automatic logic ends_group(kind_e k);
        return is_ctrl(k) || (k == KIND_STORE);
    endfunction

    function automatic logic writes_rd(kind_e k);
        return k inside {KIND_ALU, KIND_LOAD, KIND_JAL, KIND_JALR};
    endfunction

endpackage

// File: rtl/rob_multi_commit_sel.sv
// rtl/rob_multi_commit_sel.sv - slot eligibility chain over the head window, with mispredict flag
module rob_commit_sel
    import rob_pkg::*;
#(
    parameter int COMMIT_W = 2
) (
    input  logic [COMMIT_W-1:0] win_busy,
    input  logic [COMMIT_W-1:0] win_ready,
    input  logic [COMMIT_W-1:0] win_pred_jump,
    input  logic [COMMIT_W-1:0] win_jump,
    input  kind_e               win_kind    [COMMIT_W],
    input  logic [31:0]         win_pred_pc [COMMIT_W],
    input  logic [31:0]         win_pc_next [COMMIT_W],
    output logic [COMMIT_W-1:0] fire,
    output logic                mispredict
);

    always_comb begin
        logic chain_open;
        fire       = '0;
        mispredict = 1'b0;
        chain_open = 1'b1;
        for (int s = 0; s < COMMIT_W; s++) begin
            fire[s] = chain_open && win_busy[s] && win_ready[s];
            if (fire[s] && win_kind[s] == KIND_BRANCH && win_pred_jump[s] != win_jump[s])
                mispredict = 1'b1;
            if (fire[s] && win_kind[s] == KIND_JALR && win_pred_pc[s] != win_pc_next[s])
                mispredict = 1'b1;
            chain_open = fire[s] && !ends_group(win_kind[s]);
        end
    end

endmodule

// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - multi-commit reorder buffer with CDB bypass lookup and registered commit outputs
module rob_multi
    import rob_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int IDW      = $clog2(DEPTH),
    parameter int COMMIT_W = 2,
    parameter int N_CDB    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [IDW-1:0]        alloc_id,
    input  logic [2:0]            alloc_kind,
    input  logic [31:0]           alloc_pc,
    input  logic [31:0]           alloc_pred_pc,
    input  logic                  alloc_pred_jump,
    input  logic [4:0]            alloc_rd,
    input  logic [31:0]           alloc_code,
    input  logic [2*IDW-1:0]      q_id,
    input  logic [1:0]            q_valid,
    output logic [1:0]            q_ready,
    output logic [63:0]           q_value,
    input  logic [N_CDB-1:0]      cdb_valid,
    input  logic [N_CDB*IDW-1:0]  cdb_id,
    input  logic [N_CDB*32-1:0]   cdb_value,
    input  logic [N_CDB-1:0]      cdb_jump,
    input  logic [N_CDB*32-1:0]   cdb_pc_next,
    output logic [COMMIT_W-1:0]   commit_valid,
    output logic [COMMIT_W-1:0]   commit_rd_we,
    output logic [COMMIT_W*5-1:0] commit_rd,
    output logic [COMMIT_W*32-1:0] commit_value,
    output logic [COMMIT_W*IDW-1:0] commit_id,
    output logic                  store_commit,
    output logic [IDW-1:0]        store_id,
    output logic                  pred_train,
    output logic                  pred_taken,
    output logic [31:0]           pred_code,
    output logic                  flush,
    output logic [31:0]           flush_pc
);

    logic [IDW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [IDW:0]    count_q, count_d;
    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
    rob_entry_t      ent_q [DEPTH];
    rob_entry_t      ent_d [DEPTH];

    logic [COMMIT_W-1:0]     commit_valid_q, commit_valid_d, commit_rd_we_q, commit_rd_we_d;
    logic [COMMIT_W*5-1:0]   commit_rd_q, commit_rd_d;
    logic [COMMIT_W*32-1:0]  commit_value_q, commit_value_d;
    logic [COMMIT_W*IDW-1:0] commit_id_q, commit_id_d;
    logic                    store_commit_q, store_commit_d, pred_train_q, pred_train_d;
    logic                    pred_taken_q, pred_taken_d, flush_q, flush_d;
    logic [IDW-1:0]          store_id_q, store_id_d;
    logic [31:0]             pred_code_q, pred_code_d, flush_pc_q, flush_pc_d;

    logic [IDW-1:0]      win_id      [COMMIT_W];
    kind_e               win_kind    [COMMIT_W];
    logic [31:0]         win_pred_pc [COMMIT_W];
    logic [31:0]         win_pc_next [COMMIT_W];
    logic [COMMIT_W-1:0] win_busy, win_ready, win_pred_jump, win_jump;
    logic [COMMIT_W-1:0] fire_raw, fire;
    logic                mis_raw, mispredict, alloc_fire;
    logic [IDW:0]        n_commit;
    logic                unused_alloc_pc;

    assign unused_alloc_pc = ^alloc_pc;
    assign alloc_ready     = (count_q != (IDW+1)'(DEPTH));
    assign alloc_id        = tail_q;
    assign alloc_fire      = rdy && alloc_valid && alloc_ready;

    always_comb begin
        for (int s = 0; s < COMMIT_W; s++) begin
            win_id[s]        = head_q + IDW'(s);
            win_busy[s]      = busy_q[win_id[s]];
            win_ready[s]     = ready_q[win_id[s]];
            win_kind[s]      = ent_q[win_id[s]].kind;
            win_pred_jump[s] = ent_q[win_id[s]].pred_jump;
            win_jump[s]      = ent_q[win_id[s]].jump;
            win_pred_pc[s]   = ent_q[win_id[s]].pred_pc;
            win_pc_next[s]   = ent_q[win_id[s]].pc_next;
        end
    end

    rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_commit_sel (
        .win_busy      (win_busy),
        .win_ready     (win_ready),
        .win_pred_jump (win_pred_jump),
        .win_jump      (win_jump),
        .win_kind      (win_kind),
        .win_pred_pc   (win_pred_pc),
        .win_pc_next   (win_pc_next),
        .fire          (fire_raw),
        .mispredict    (mis_raw)
    );

    assign fire       = fire_raw & {COMMIT_W{rdy}};
    assign mispredict = mis_raw && rdy;

    // Operand lookup: a same-cycle broadcast overrides stored state, highest port last.
    always_comb begin
        q_ready = '0;
        q_value = '0;
        for (int x = 0; x < 2; x++) begin
            if (!q_valid[x]) begin
                q_ready[x] = 1'b1;
            end else begin
                q_ready[x]            = ready_q[q_id[x*IDW +: IDW]];
                q_value[x*32 +: 32]   = ent_q[q_id[x*IDW +: IDW]].value;
                for (int p = 0; p < N_CDB; p++) begin
                    if (cdb_valid[p] && cdb_id[p*IDW +: IDW] == q_id[x*IDW +: IDW]) begin
                        q_ready[x]          = 1'b1;
                        q_value[x*32 +: 32] = cdb_value[p*32 +: 32];
                    end
                end
            end
        end
    end

    always_comb begin
        n_commit = '0;
        for (int s = 0; s < COMMIT_W; s++)
            n_commit = n_commit + (IDW+1)'(fire[s]);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        ent_d   = ent_q;
        if (rdy) begin
            for (int p = 0; p < N_CDB; p++) begin
                if (cdb_valid[p] && busy_q[cdb_id[p*IDW +: IDW]]) begin
                    ent_d[cdb_id[p*IDW +: IDW]].value   = cdb_value[p*32 +: 32];
                    ent_d[cdb_id[p*IDW +: IDW]].jump    = cdb_jump[p];
                    ent_d[cdb_id[p*IDW +: IDW]].pc_next = cdb_pc_next[p*32 +: 32];
                    ready_d[cdb_id[p*IDW +: IDW]]       = 1'b1;
                end
            end
            if (alloc_fire) begin
                ent_d[tail_q] = '{kind: kind_e'(alloc_kind), rd: alloc_rd,
                                  pred_pc: alloc_pred_pc, pred_jump: alloc_pred_jump,
                                  code: alloc_code, value: '0, jump: 1'b0, pc_next: '0};
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            for (int s = 0; s < COMMIT_W; s++) begin
                if (fire[s]) begin
                    busy_d[win_id[s]]  = 1'b0;
                    ready_d[win_id[s]] = 1'b0;
                end
            end
            head_d  = head_q + n_commit[IDW-1:0];
            count_d = count_q + (IDW+1)'(alloc_fire) - n_commit;
            if (mispredict) begin
                busy_d  = '0;
                ready_d = '0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    // Registered commit-side outputs; data fields hold when their slot is idle.
    always_comb begin
        commit_valid_d = fire;
        commit_rd_we_d = '0;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_id_d    = commit_id_q;
        store_commit_d = 1'b0;
        store_id_d     = store_id_q;
        pred_train_d   = 1'b0;
        pred_taken_d   = pred_taken_q;
        pred_code_d    = pred_code_q;
        flush_d        = mispredict;
        flush_pc_d     = flush_pc_q;
        for (int s = 0; s < COMMIT_W; s++) begin
            if (fire[s]) begin
                commit_rd_we_d[s]          = writes_rd(win_kind[s]) && (ent_q[win_id[s]].rd != 5'd0);
                commit_rd_d[s*5 +: 5]      = ent_q[win_id[s]].rd;
                commit_value_d[s*32 +: 32] = ent_q[win_id[s]].value;
                commit_id_d[s*IDW +: IDW]  = win_id[s];
                if (win_kind[s] == KIND_STORE) begin
                    store_commit_d = 1'b1;
                    store_id_d     = win_id[s];
                end
                if (is_ctrl(win_kind[s])) begin
                    pred_train_d = 1'b1;
                    pred_taken_d = win_jump[s];
                    pred_code_d  = ent_q[win_id[s]].code;
                    if (mispredict)
                        flush_pc_d = win_pc_next[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            commit_valid_q <= '0;
            commit_rd_we_q <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_id_q    <= '0;
            store_commit_q <= 1'b0;
            store_id_q     <= '0;
            pred_train_q   <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_code_q    <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_we_q <= commit_rd_we_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_id_q    <= commit_id_d;
            store_commit_q <= store_commit_d;
            store_id_q     <= store_id_d;
            pred_train_q   <= pred_train_d;
            pred_taken_q   <= pred_taken_d;
            pred_code_q    <= pred_code_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Payload is qualified by busy/ready, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign commit_valid = commit_valid_q;
    assign commit_rd_we = commit_rd_we_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_id    = commit_id_q;
    assign store_commit = store_commit_q;
    assign store_id     = store_id_q;
    assign pred_train   = pred_train_q;
    assign pred_taken   = pred_taken_q;
    assign pred_code    = pred_code_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_rob_multi.sv
// tb/tb_rob_multi.sv - directed self-checking bench for rob_multi
module tb_rob_multi;

    localparam int DEPTH = 16, IDW = 4, CW = 2, NC = 2;

    logic clk, rst, rdy;
    logic alloc_valid, alloc_ready, alloc_pred_jump;
    logic [IDW-1:0] alloc_id, store_id;
    logic [2:0] alloc_kind;
    logic [31:0] alloc_pc, alloc_pred_pc, alloc_code, pred_code, flush_pc;
    logic [4:0] alloc_rd;
    logic [2*IDW-1:0] q_id;
    logic [1:0] q_valid, q_ready;
    logic [63:0] q_value;
    logic [NC-1:0] cdb_valid, cdb_jump;
    logic [NC*IDW-1:0] cdb_id;
    logic [NC*32-1:0] cdb_value, cdb_pc_next;
    logic [CW-1:0] commit_valid, commit_rd_we;
    logic [CW*5-1:0] commit_rd;
    logic [CW*32-1:0] commit_value;
    logic [CW*IDW-1:0] commit_id;
    logic store_commit, pred_train, pred_taken, flush;

    int n_pass = 0;
    int n_total = 0;

    rob_multi #(.DEPTH(DEPTH), .IDW(IDW), .COMMIT_W(CW), .N_CDB(NC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .alloc_kind(alloc_kind), .alloc_pc(alloc_pc), .alloc_pred_pc(alloc_pred_pc),
        .alloc_pred_jump(alloc_pred_jump), .alloc_rd(alloc_rd), .alloc_code(alloc_code),
        .q_id(q_id), .q_valid(q_valid), .q_ready(q_ready), .q_value(q_value),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
        .cdb_jump(cdb_jump), .cdb_pc_next(cdb_pc_next),
        .commit_valid(commit_valid), .commit_rd_we(commit_rd_we), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_id(commit_id),
        .store_commit(store_commit), .store_id(store_id),
        .pred_train(pred_train), .pred_taken(pred_taken), .pred_code(pred_code),
        .flush(flush), .flush_pc(flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cdb_clear();
        cdb_valid = '0; cdb_id = '0; cdb_value = '0; cdb_jump = '0; cdb_pc_next = '0;
    endtask

    task automatic cdb_set(input int p, input logic [3:0] id, input logic [31:0] val,
                           input logic j, input logic [31:0] pcn);
        cdb_valid[p]            = 1'b1;
        cdb_id[p*IDW +: IDW]    = id;
        cdb_value[p*32 +: 32]   = val;
        cdb_jump[p]             = j;
        cdb_pc_next[p*32 +: 32] = pcn;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; q_valid = '0; q_id = '0;
        cdb_clear();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [2:0] kind, input logic [4:0] rd,
                         input logic pj, input logic [31:0] ppc);
        alloc_valid = 1'b1; alloc_kind = kind; alloc_rd = rd;
        alloc_pred_jump = pj; alloc_pred_pc = ppc; alloc_pc = 32'h1000; alloc_code = 32'h13;
        tick();
        alloc_valid = 1'b0;
    endtask

    initial begin
        alloc_kind = '0; alloc_rd = '0; alloc_pred_jump = 1'b0;
        alloc_pred_pc = '0; alloc_pc = '0; alloc_code = '0;
        do_reset();
        check("rst_commit_valid", commit_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_alloc_id", alloc_id, 0);
        check("rst_alloc_ready", alloc_ready, 1);

        // Fill all 16 entries.
        for (int i = 0; i < 16; i++) begin
            alloc(3'd0, 5'(i + 1), 1'b0, 32'h0);
            if (i == 14) check("fill15_ready", alloc_ready, 1);
        end
        check("full_ready", alloc_ready, 0);
        check("full_alloc_id", alloc_id, 0);
        cdb_set(0, 4'd0, 32'h5, 1'b0, 32'h0);
        tick(); cdb_clear();
        check("commit_latency", commit_valid, 2'b00);
        tick();
        check("full_commit_valid", commit_valid, 2'b01);
        check("full_commit_rd", commit_rd[4:0], 5'd1);
        check("full_commit_value", commit_value[31:0], 32'h5);
        check("full_commit_we", commit_rd_we, 2'b01);
        check("full_ready_again", alloc_ready, 1);

        // Two ALU entries commit together.
        do_reset();
        alloc(3'd0, 5'd3, 1'b0, 32'h0);
        alloc(3'd0, 5'd4, 1'b0, 32'h0);
        cdb_set(0, 4'd0, 32'h11, 1'b0, 32'h0);
        cdb_set(1, 4'd1, 32'h22, 1'b0, 32'h0);
        tick(); cdb_clear(); tick();
        check("dual_valid", commit_valid, 2'b11);
        check("dual_id", commit_id, 8'h10);
        check("dual_rd", commit_rd, {5'd4, 5'd3});
        check("dual_value", commit_value, {32'h22, 32'h11});
        tick();
        check("dual_pulse_end", commit_valid, 2'b00);

        // Store stops the commit chain.
        do_reset();
        alloc(3'd2, 5'd0, 1'b0, 32'h0);
        alloc(3'd0, 5'd5, 1'b0, 32'h0);
        cdb_set(0, 4'd0, 32'h0, 1'b0, 32'h0);
        cdb_set(1, 4'd1, 32'h33, 1'b0, 32'h0);
        tick(); cdb_clear(); tick();
        check("store_valid", commit_valid, 2'b01);
        check("store_commit", store_commit, 1);
        check("store_id", store_id, 0);
        check("store_rd_we", commit_rd_we, 2'b00);
        tick();
        check("after_store_valid", commit_valid, 2'b01);
        check("after_store_id", commit_id[3:0], 4'd1);
        check("after_store_sc", store_commit, 0);
        check("after_store_we", commit_rd_we, 2'b01);

        // Mispredicted branch behind an ALU, with a younger ready ALU discarded.
        do_reset();
        alloc(3'd0, 5'd1, 1'b0, 32'h0);
        alloc(3'd3, 5'd0, 1'b0, 32'h0);
        alloc(3'd0, 5'd2, 1'b0, 32'h0);
        cdb_set(0, 4'd2, 32'h7, 1'b0, 32'h0);
        cdb_set(1, 4'd1, 32'h0, 1'b1, 32'h1040);
        tick(); cdb_clear();
        cdb_set(0, 4'd0, 32'h9, 1'b0, 32'h0);
        tick(); cdb_clear(); tick();
        check("br_valid", commit_valid, 2'b11);
        check("br_train", pred_train, 1);
        check("br_taken", pred_taken, 1);
        check("br_flush", flush, 1);
        check("br_flush_pc", flush_pc, 32'h1040);
        check("br_rd_we", commit_rd_we, 2'b01);
        check("br_alloc_id", alloc_id, 0);
        tick();
        check("br_flush_pulse", flush, 0);
        check("br_discard", commit_valid, 2'b00);

        // JALR target mispredict, then a correct JALR.
        do_reset();
        alloc(3'd5, 5'd1, 1'b1, 32'h200);
        cdb_set(0, 4'd0, 32'h1004, 1'b1, 32'h300);
        tick(); cdb_clear(); tick();
        check("jalr_flush", flush, 1);
        check("jalr_flush_pc", flush_pc, 32'h300);
        do_reset();
        alloc(3'd5, 5'd1, 1'b1, 32'h200);
        cdb_set(0, 4'd0, 32'h1004, 1'b1, 32'h200);
        tick(); cdb_clear(); tick();
        check("jalr_ok_flush", flush, 0);
        check("jalr_ok_valid", commit_valid, 2'b01);
        check("jalr_ok_we", commit_rd_we, 2'b01);
        check("jalr_ok_train", pred_train, 1);

        // Lookup bypass and CDB port priority.
        do_reset();
        for (int i = 0; i < 4; i++) alloc(3'd0, 5'd1, 1'b0, 32'h0);
        q_valid = 2'b01; q_id = {4'd0, 4'd3};
        #1;
        check("q_not_ready", q_ready, 2'b10);
        check("q_k_value", q_value[63:32], 32'h0);
        cdb_set(0, 4'd3, 32'hAB, 1'b0, 32'h0);
        #1;
        check("q_bypass_ready", q_ready, 2'b11);
        check("q_bypass_value", q_value[31:0], 32'hAB);
        cdb_set(1, 4'd3, 32'hCD, 1'b0, 32'h0);
        #1;
        check("q_bypass_hi", q_value[31:0], 32'hCD);
        tick(); cdb_clear();
        #1;
        check("q_stored_ready", q_ready[0], 1);
        check("q_stored_hi", q_value[31:0], 32'hCD);
        cdb_set(0, 4'd9, 32'h55, 1'b0, 32'h0);
        tick(); cdb_clear();
        q_id = {4'd0, 4'd9};
        #1;
        check("q_nonbusy_ignored", q_ready[0], 0);
        q_valid = '0;

        // Tail wrap and rdy hold.
        do_reset();
        for (int i = 0; i < 15; i++) alloc(3'd0, 5'd1, 1'b0, 32'h0);
        check("wrap_id15", alloc_id, 15);
        cdb_set(0, 4'd0, 32'h1, 1'b0, 32'h0);
        tick(); cdb_clear(); tick();
        alloc(3'd0, 5'd1, 1'b0, 32'h0);
        check("wrap_id0", alloc_id, 0);
        check("wrap_ready", alloc_ready, 1);
        cdb_set(0, 4'd1, 32'h77, 1'b0, 32'h0);
        tick(); cdb_clear();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_hold", commit_valid, 2'b00);
        end
        rdy = 1'b1;
        tick();
        check("rdy_resume_valid", commit_valid, 2'b01);
        check("rdy_resume_id", commit_id[3:0], 4'd1);
        check("rdy_resume_value", commit_value[31:0], 32'h77);

        // Reset while entries are live.
        do_reset();
        for (int i = 0; i < 8; i++) alloc(3'd0, 5'd2, 1'b0, 32'h0);
        cdb_set(0, 4'd0, 32'h99, 1'b0, 32'h0);
        tick(); cdb_clear(); tick();
        rst = 1'b1; rdy = 1'b0;
        tick();
        check("mid_rst_valid", commit_valid, 0);
        check("mid_rst_value", commit_value, 0);
        check("mid_rst_rd", commit_rd, 0);
        check("mid_rst_alloc_id", alloc_id, 0);
        rst = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc(3'd0, 5'd1, 1'b0, 32'h0);
            if (i == 14) check("mid_rst_count15", alloc_ready, 1);
        end
        check("mid_rst_count16", alloc_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
